// File: rtl/led_stream_receiver.sv
// ---------------------------------------------------------------------------
// led_stream_receiver
//
// This block is the receive end of the serial LED link. It deserializes the
// bit stream and the active-low latch pulse that the LED shift driver
// produces, and presents each completed frame as a parallel word in natural
// bit order. It runs in the same clock domain as the transmitter.
//
// Parameters:
//   WIDTH        frame length in bits (even, >= 4)
//   SWAP_HALVES  1: the wire carries the low half MSB-first, then the high
//                half MSB-first. 0: the wire carries the word plainly,
//                MSB-first.
//
// Ports:
//   i_CLK         system clock, rising edge
//   i_RESET       synchronous reset, active-high
//   i_SerData     serial data bit, valid while i_SerEn=1
//   i_SerEn       bit strobe
//   i_SerLatch    frame latch, active low; its first low cycle ends a frame
//   o_Data16      last good frame, restored to natural bit order
//   o_Valid       one-cycle pulse: o_Data16 updated
//   o_FrameErr    one-cycle pulse: latch seen with bit count != WIDTH
//   o_Busy        a partial frame is held (bit count > 0)
//
// Optional feature, macro LED_RX_FRAME_COUNT_EN:
//   o_FrameCount  good-frame counter, wraps 255 -> 0
//   o_ErrCount    frame-error counter, saturates at 255
// ---------------------------------------------------------------------------
module led_stream_receiver #(
  parameter int WIDTH       = 16,
  parameter bit SWAP_HALVES = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_SerData,
  input  logic             i_SerEn,
  input  logic             i_SerLatch,
  output logic [WIDTH-1:0] o_Data16,
  output logic             o_Valid,
  output logic             o_FrameErr,
`ifdef LED_RX_FRAME_COUNT_EN
  output logic             o_Busy,
  output logic [7:0]       o_FrameCount,
  output logic [7:0]       o_ErrCount
`else
  output logic             o_Busy
`endif
);

  localparam int HALF = WIDTH / 2;
  // The counter must be able to hold WIDTH+1, which is the overrun marker.
  localparam int CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVR  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVER
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic             latch_q;
  logic             latch_fall;

  // This function restores the natural bit order of a shifted-in frame.
  function automatic logic [WIDTH-1:0] unswap(input logic [WIDTH-1:0] s);
    if (SWAP_HALVES)
      return {s[HALF-1:0], s[WIDTH-1:HALF]};
    else
      return s;
  endfunction

  // Only the first low cycle of the latch ends a frame. A latch that is held
  // low keeps latch_q low, so the later low cycles produce no second event.
  assign latch_fall = !i_SerLatch && latch_q;

  always_ff @(posedge i_CLK) begin
    // NOTE: every register in this block uses non-blocking assignment. The
    // branches below then read the pre-edge values of count and state, which
    // keeps the behaviour independent of statement order.
    if (i_RESET) begin
      state      <= IDLE;
      sr         <= '0;
      count      <= '0;
      latch_q    <= 1'b1;
      o_Data16   <= '0;
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      latch_q    <= i_SerLatch;
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      if (latch_fall) begin
        // The latch has priority over a strobe in the same cycle, so that
        // bit is dropped and not counted.
        state  <= IDLE;
        count  <= '0;
        o_Busy <= 1'b0;
        if (count == CNT_FULL) begin
          o_Data16 <= unswap(sr);
          o_Valid  <= 1'b1;
        end else begin
          o_FrameErr <= 1'b1;
        end
      end else if (i_SerEn && i_SerLatch) begin
        sr     <= {sr[WIDTH-2:0], i_SerData};
        o_Busy <= 1'b1;
        if (state == OVER) begin
          // The counter saturates here. Later bits are still shifted in,
          // but the frame is already marked as bad.
          count <= CNT_OVR;
        end else if (count == CNT_FULL) begin
          count <= CNT_OVR;
          state <= OVER;
        end else begin
          count <= count + 1'b1;
          state <= SHIFT;
        end
      end
    end
  end

`ifdef LED_RX_FRAME_COUNT_EN
  // The counters follow the registered pulses, so each one settles one cycle
  // after its pulse.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_FrameCount <= '0;
      o_ErrCount   <= '0;
    end else begin
      if (o_Valid)
        o_FrameCount <= o_FrameCount + 8'd1;
      if (o_FrameErr && (o_ErrCount != 8'hFF))
        o_ErrCount <= o_ErrCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_led_stream_receiver.sv
// ---------------------------------------------------------------------------
// tb_led_stream_receiver
//
// Self-checking bench for led_stream_receiver with WIDTH=16 and
// SWAP_HALVES=1. When a latch is driven, the expected outcome of that frame
// is pushed to a queue. It is popped and compared in the cycle in which the
// DUT presents the result. Inputs change on the falling edge of the clock,
// and outputs are sampled on the falling edge as well.
// The counter scenario runs only when LED_RX_FRAME_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_led_stream_receiver;

  localparam int WIDTH = 16;

  typedef struct {
    logic             valid;
    logic             err;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             i_CLK = 1'b0;
  logic             i_RESET;
  logic             i_SerData;
  logic             i_SerEn;
  logic             i_SerLatch;
  logic [WIDTH-1:0] o_Data16;
  logic             o_Valid;
  logic             o_FrameErr;
  logic             o_Busy;
`ifdef LED_RX_FRAME_COUNT_EN
  logic [7:0]       o_FrameCount;
  logic [7:0]       o_ErrCount;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 i_CLK = ~i_CLK;

  led_stream_receiver #(.WIDTH(WIDTH), .SWAP_HALVES(1'b1)) dut (
    .i_CLK       (i_CLK),
    .i_RESET     (i_RESET),
    .i_SerData   (i_SerData),
    .i_SerEn     (i_SerEn),
    .i_SerLatch  (i_SerLatch),
    .o_Data16    (o_Data16),
    .o_Valid     (o_Valid),
    .o_FrameErr  (o_FrameErr),
`ifdef LED_RX_FRAME_COUNT_EN
    .o_Busy      (o_Busy),
    .o_FrameCount(o_FrameCount),
    .o_ErrCount  (o_ErrCount)
`else
    .o_Busy      (o_Busy)
`endif
  );

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_CLK);
      i_SerEn    = 1'b0;
      i_SerLatch = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge i_CLK);
      i_SerEn    = 1'b1;
      i_SerLatch = 1'b1;
      i_SerData  = v[i];
    end
  endtask

  // The wire order is the low byte MSB-first, then the high byte MSB-first.
  task automatic send_word(input logic [15:0] w);
    send_bits({16'h0, w[7:0], w[15:8]}, 16);
  endtask

  // This task drives a one-cycle latch, pushes the expected outcome, then
  // pops and compares it in the cycle after the latch is sampled.
  task automatic latch_frame(input string name, input logic ev, input logic ee,
                             input logic [WIDTH-1:0] ed);
    exp_t e;
    e.valid = ev; e.err = ee; e.data = ed;
    sb_q.push_back(e);
    @(negedge i_CLK);
    i_SerEn    = 1'b0;
    i_SerLatch = 1'b0;
    @(negedge i_CLK);
    i_SerLatch = 1'b1;
    e = sb_q.pop_front();
    n_checks++;
    if (o_Valid !== e.valid || o_FrameErr !== e.err || o_Data16 !== e.data) begin
      n_errors++;
      $display("FAIL %s: got valid=%b err=%b data=%h, expected valid=%b err=%b data=%h",
               name, o_Valid, o_FrameErr, o_Data16, e.valid, e.err, e.data);
    end
    n_checks++;
    if (o_Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy after latch: got %b, expected 0", name, o_Busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    i_RESET = 1'b1; i_SerEn = 1'b0; i_SerLatch = 1'b1; i_SerData = 1'b0;
    repeat (2) @(negedge i_CLK);
    n_checks++;
    if (o_Data16 !== '0 || o_Valid !== 1'b0 || o_FrameErr !== 1'b0 || o_Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got data=%h valid=%b err=%b busy=%b, expected all 0",
               o_Data16, o_Valid, o_FrameErr, o_Busy);
    end
    i_RESET = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    send_bits(32'h1FF, 9);
    idle(1);
    n_checks++;
    if (o_Busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_partial: got %b, expected 1", o_Busy);
    end
    @(negedge i_CLK);
    i_RESET = 1'b1;
    @(negedge i_CLK);
    i_RESET = 1'b0;
    n_checks++;
    if (o_Busy !== 1'b0 || o_Data16 !== '0 || o_FrameErr !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_frame: got busy=%b data=%h err=%b, expected 0/0000/0",
               o_Busy, o_Data16, o_FrameErr);
    end
    latch_frame("latch_after_reset", 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_good_frame;
    send_word(16'h1234);
    latch_frame("good_1234", 1'b1, 1'b0, 16'h1234);
    idle(1);
    n_checks++;
    if (o_Valid !== 1'b0 || o_Data16 !== 16'h1234) begin
      n_errors++;
      $display("FAIL valid_one_cycle: got valid=%b data=%h, expected 0/1234", o_Valid, o_Data16);
    end
    send_word(16'hBEEF);
    latch_frame("good_beef", 1'b1, 1'b0, 16'hBEEF);
    send_word(16'h1234);
    latch_frame("good_1234_again", 1'b1, 1'b0, 16'h1234);
  endtask

  task automatic test_short_frame;
    send_bits(32'h7FFF, 15);
    latch_frame("short_15", 1'b0, 1'b1, 16'h1234);
  endtask

  task automatic test_overrun;
    send_bits(32'hABCDE, 20);
    latch_frame("overrun_20", 1'b0, 1'b1, 16'h1234);
    send_bits(32'h1FFFF, 17);
    latch_frame("overrun_17", 1'b0, 1'b1, 16'h1234);
    send_word(16'h5AA5);
    latch_frame("after_overrun", 1'b1, 1'b0, 16'h5AA5);
  endtask

  task automatic test_latch_in_idle;
    idle(2);
    latch_frame("idle_latch", 1'b0, 1'b1, 16'h5AA5);
  endtask

  // A strobe arrives together with the latch, and the latch is held low
  // for three cycles.
  task automatic test_strobe_latch_held;
    send_word(16'hC33C);
    @(negedge i_CLK);
    i_SerEn = 1'b1; i_SerData = 1'b1; i_SerLatch = 1'b0;
    @(negedge i_CLK);
    n_checks++;
    if (o_Valid !== 1'b1 || o_FrameErr !== 1'b0 || o_Data16 !== 16'hC33C) begin
      n_errors++;
      $display("FAIL strobe_latch: got valid=%b err=%b data=%h, expected 1/0/c33c",
               o_Valid, o_FrameErr, o_Data16);
    end
    i_SerEn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_CLK);
      n_checks++;
      if (o_Valid !== 1'b0 || o_FrameErr !== 1'b0 || o_Busy !== 1'b0) begin
        n_errors++;
        $display("FAIL held_latch_cycle%0d: got valid=%b err=%b busy=%b, expected 0/0/0",
                 i, o_Valid, o_FrameErr, o_Busy);
      end
    end
    i_SerLatch = 1'b1;
    // This back-to-back frame checks that the receiver recovered.
    send_word(16'h0F0F);
    latch_frame("after_held", 1'b1, 1'b0, 16'h0F0F);
  endtask

`ifdef LED_RX_FRAME_COUNT_EN
  task automatic test_counters;
    @(negedge i_CLK);
    i_RESET = 1'b1;
    @(negedge i_CLK);
    i_RESET = 1'b0;
    for (int f = 0; f < 256; f++) begin
      send_word(16'(f));
      latch_frame("cnt_frame", 1'b1, 1'b0, 16'(f));
      if (f == 254) begin
        idle(1);
        n_checks++;
        if (o_FrameCount !== 8'd255) begin
          n_errors++;
          $display("FAIL frame_count_255: got %0d, expected 255", o_FrameCount);
        end
      end
    end
    idle(1);
    n_checks++;
    if (o_FrameCount !== 8'd0) begin
      n_errors++;
      $display("FAIL frame_count_wrap: got %0d, expected 0", o_FrameCount);
    end
    for (int f = 0; f < 300; f++)
      latch_frame("cnt_err", 1'b0, 1'b1, 16'h00FF);
    idle(1);
    n_checks++;
    if (o_ErrCount !== 8'd255) begin
      n_errors++;
      $display("FAIL err_count_sat: got %0d, expected 255", o_ErrCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_latch_in_idle();
    test_strobe_latch_held();
`ifdef LED_RX_FRAME_COUNT_EN
    test_counters();
`endif
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
